// File: rtl/adder_tree_pipe.sv
// Pipelined signed adder tree: one register stage per tree level, with a valid
// pipe alongside and a global stall. ADDER_TREE_SAT_EN clamps the result to WIDTH bits.
module adder_tree_pipe #(
  parameter  int WIDTH      = 16,
  parameter  int NUM_INPUTS = 5,
  localparam int LEVELS     = (NUM_INPUTS <= 1) ? 1 : $clog2(NUM_INPUTS),
  localparam int OUT_WIDTH  = WIDTH + $clog2(NUM_INPUTS),
`ifdef ADDER_TREE_SAT_EN
  localparam int SUM_W      = WIDTH
`else
  localparam int SUM_W      = OUT_WIDTH
`endif
) (
  input  logic                          i_clock,
  input  logic                          i_reset_n,
  input  logic                          i_enable,
  input  logic                          i_valid,
  input  logic [NUM_INPUTS*WIDTH-1:0]   i_data,
  output logic signed [SUM_W-1:0]       o_sum,
  output logic                          o_valid,
  output logic                          o_sat
);

  localparam int FINAL_W = WIDTH + LEVELS;

  // Number of nodes produced by tree level lvl (level -1 is the raw input words).
  function automatic int level_count(input int lvl);
    int c;
    c = NUM_INPUTS;
    for (int i = 0; i <= lvl; i++) c = (c + 1) / 2;
    return c;
  endfunction

  for (genvar l = 0; l < LEVELS; l++) begin : g_lvl
    localparam int IN_W   = WIDTH + l;
    localparam int LW     = WIDTH + l + 1;
    localparam int IN_CNT = level_count(l - 1);
    localparam int CNT    = level_count(l);

    logic signed [IN_W-1:0] src   [IN_CNT];
    logic signed [LW-1:0]   sum_d [CNT];

    if (l == 0) begin : g_src
      for (genvar k = 0; k < IN_CNT; k++) begin : g_w
        assign src[k] = i_data[k*WIDTH +: WIDTH];
      end
    end else begin : g_src
      for (genvar k = 0; k < IN_CNT; k++) begin : g_w
        assign src[k] = g_lvl[l-1].g_reg.sum_q[k];
      end
    end

    // An unpaired last word is only widened and carried to the next level.
    for (genvar j = 0; j < CNT; j++) begin : g_node
      if (2*j + 1 < IN_CNT) begin : g_pair
        assign sum_d[j] = LW'(src[2*j]) + LW'(src[2*j+1]);
      end else begin : g_pass
        assign sum_d[j] = LW'(src[2*j]);
      end
    end

    // The last level is registered by the output stage below.
    if (l < LEVELS - 1) begin : g_reg
      logic signed [LW-1:0] sum_q [CNT];

      always_ff @(posedge i_clock or negedge i_reset_n) begin
        if (!i_reset_n) begin
          sum_q <= '{default: '0};
        end else if (i_enable) begin
          sum_q <= sum_d;
        end
      end
    end
  end

  logic signed [FINAL_W-1:0] final_sum;
  logic signed [SUM_W-1:0]   out_sum_d, out_sum_q;
  logic [LEVELS-1:0]         valid_d, valid_q;

  assign final_sum = g_lvl[LEVELS-1].sum_d[0];

`ifdef ADDER_TREE_SAT_EN
  logic sat_d, sat_q;

  // Bits above the WIDTH-bit sign position must all match the sign, else clamp.
  always_comb begin
    out_sum_d = final_sum[WIDTH-1:0];
    sat_d     = 1'b0;
    if (final_sum[FINAL_W-1:WIDTH-1] != {(FINAL_W-WIDTH+1){final_sum[FINAL_W-1]}}) begin
      sat_d     = 1'b1;
      out_sum_d = final_sum[FINAL_W-1] ? {1'b1, {(WIDTH-1){1'b0}}}
                                       : {1'b0, {(WIDTH-1){1'b1}}};
    end
  end

  always_ff @(posedge i_clock or negedge i_reset_n) begin
    if (!i_reset_n) begin
      sat_q <= 1'b0;
    end else if (i_enable) begin
      sat_q <= sat_d;
    end
  end

  assign o_sat = sat_q;
`else
  always_comb begin
    out_sum_d = SUM_W'(final_sum);
  end

  assign o_sat = 1'b0;
`endif

  always_comb begin
    valid_d = valid_q;
    if (i_enable) valid_d = LEVELS'({valid_q, i_valid});
  end

  always_ff @(posedge i_clock or negedge i_reset_n) begin
    if (!i_reset_n) begin
      valid_q   <= '0;
      out_sum_q <= '0;
    end else if (i_enable) begin
      valid_q   <= valid_d;
      out_sum_q <= out_sum_d;
    end
  end

  assign o_sum   = out_sum_q;
  assign o_valid = valid_q[LEVELS-1];

endmodule

// File: tb/tb_adder_tree_pipe.sv
// Self-checking bench for adder_tree_pipe: a queue-based model checks the default
// 5-input tree every cycle; extra 3/1/8-input instances cover the odd-size trees.
module tb_adder_tree_pipe;

`ifdef ADDER_TREE_SAT_EN
  localparam int MW = 16;
  localparam int W3 = 16;
  localparam int W8 = 16;
  localparam longint EXTREME_EXP = -32768;
  localparam longint EXTREME_SAT = 1;
  localparam longint N8_EXP      = 32767;
  localparam longint N8_SAT      = 1;
`else
  localparam int MW = 19;
  localparam int W3 = 18;
  localparam int W8 = 19;
  localparam longint EXTREME_EXP = -163840;
  localparam longint EXTREME_SAT = 0;
  localparam longint N8_EXP      = 262136;
  localparam longint N8_SAT      = 0;
`endif
  localparam int LEVELS = 3;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic en = 1'b1;

  logic                 m_valid = 1'b0;
  logic [79:0]          m_data = '0;
  logic signed [MW-1:0] m_sum;
  logic                 m_ovalid, m_sat;

  logic                 v3 = 1'b0, v1 = 1'b0, v8 = 1'b0;
  logic [47:0]          d3 = '0;
  logic [15:0]          d1 = '0;
  logic [127:0]         d8 = '0;
  logic signed [W3-1:0] s3;
  logic signed [15:0]   s1;
  logic signed [W8-1:0] s8;
  logic                 ov3, ov1, ov8, sat3, sat1, sat8;

  int n_checks = 0;
  int n_pass = 0;

  always #5 clk = ~clk;

  adder_tree_pipe #(.WIDTH(16), .NUM_INPUTS(5)) dut (
    .i_clock(clk), .i_reset_n(rst_n), .i_enable(en), .i_valid(m_valid),
    .i_data(m_data), .o_sum(m_sum), .o_valid(m_ovalid), .o_sat(m_sat));

  adder_tree_pipe #(.WIDTH(16), .NUM_INPUTS(3)) dut3 (
    .i_clock(clk), .i_reset_n(rst_n), .i_enable(en), .i_valid(v3),
    .i_data(d3), .o_sum(s3), .o_valid(ov3), .o_sat(sat3));

  adder_tree_pipe #(.WIDTH(16), .NUM_INPUTS(1)) dut1 (
    .i_clock(clk), .i_reset_n(rst_n), .i_enable(en), .i_valid(v1),
    .i_data(d1), .o_sum(s1), .o_valid(ov1), .o_sat(sat1));

  adder_tree_pipe #(.WIDTH(16), .NUM_INPUTS(8)) dut8 (
    .i_clock(clk), .i_reset_n(rst_n), .i_enable(en), .i_valid(v8),
    .i_data(d8), .o_sum(s8), .o_valid(ov8), .o_sat(sat8));

  task automatic check_output(input string name, input longint act, input longint exp);
    n_checks++;
    if (act == exp) n_pass++;
    else $display("[TB] FAIL %s: got %0d, expected %0d", name, act, exp);
  endtask

  function automatic longint raw_sum(input logic [79:0] d);
    longint s = 0;
    for (int k = 0; k < 5; k++) s += longint'($signed(d[k*16 +: 16]));
    return s;
  endfunction

  function automatic longint model_sum(input logic [79:0] d);
    longint s = raw_sum(d);
`ifdef ADDER_TREE_SAT_EN
    if (s > 32767) s = 32767;
    else if (s < -32768) s = -32768;
`endif
    return s;
  endfunction

  function automatic longint model_sat(input logic [79:0] d);
`ifdef ADDER_TREE_SAT_EN
    longint s = raw_sum(d);
    return (s > 32767 || s < -32768) ? 1 : 0;
`else
    return (d == d) ? 0 : 0;
`endif
  endfunction

  // Model: every captured input is due out on the enabled edge LEVELS-1 after capture.
  int     en_count = 0;
  int     tag_q[$];
  longint exp_sum_q[$];
  longint exp_sat_q[$];

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      en_count = 0;
      tag_q.delete();
      exp_sum_q.delete();
      exp_sat_q.delete();
    end else if (en) begin
      en_count++;
      while (tag_q.size() > 0 && tag_q[0] + LEVELS - 1 < en_count) begin
        void'(tag_q.pop_front());
        void'(exp_sum_q.pop_front());
        void'(exp_sat_q.pop_front());
      end
      if (m_valid) begin
        tag_q.push_back(en_count);
        exp_sum_q.push_back(model_sum(m_data));
        exp_sat_q.push_back(model_sat(m_data));
      end
    end
  end

  always @(negedge clk) begin
    if (!rst_n) begin
      check_output("cmp_reset_valid", longint'(m_ovalid), 0);
      check_output("cmp_reset_sum", longint'(m_sum), 0);
    end else begin
      automatic bit exp_v = (tag_q.size() > 0) && (tag_q[0] + LEVELS - 1 == en_count);
      check_output("cmp_valid", longint'(m_ovalid), longint'(exp_v));
      if (exp_v) begin
        check_output("cmp_sum", longint'(m_sum), exp_sum_q[0]);
        check_output("cmp_sat", longint'(m_sat), exp_sat_q[0]);
      end
`ifndef ADDER_TREE_SAT_EN
      else check_output("cmp_sat_tied", longint'(m_sat), 0);
`endif
    end
  end

  task automatic cycle();
    @(posedge clk);
    #1;
  endtask

  task automatic apply_stimulus(input int a, input int b, input int c, input int d,
                                input int e, input logic v);
    m_data  = {16'(e), 16'(d), 16'(c), 16'(b), 16'(a)};
    m_valid = v;
  endtask

  initial begin
    longint got[$];

    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;
    check_output("reset_valid", longint'(m_ovalid), 0);
    check_output("reset_sum", longint'(m_sum), 0);

    // Basic sum with single-cycle valid pulse.
    apply_stimulus(1, 2, 3, 4, 5, 1'b1);
    cycle();
    m_valid = 1'b0;
    cycle();
    cycle();
    check_output("basic_valid", longint'(m_ovalid), 1);
    check_output("basic_sum", longint'(m_sum), 15);
    cycle();
    check_output("basic_valid_drop", longint'(m_ovalid), 0);

    // Most negative inputs; result then frozen by a stall.
    apply_stimulus(-32768, -32768, -32768, -32768, -32768, 1'b1);
    cycle();
    m_valid = 1'b0;
    cycle();
    cycle();
    check_output("extreme_sum", longint'(m_sum), EXTREME_EXP);
    check_output("extreme_sat", longint'(m_sat), EXTREME_SAT);
    en = 1'b0;
    for (int i = 0; i < 3; i++) begin
      cycle();
      check_output("stall_hold_valid", longint'(m_ovalid), 1);
      check_output("stall_hold_sum", longint'(m_sum), EXTREME_EXP);
    end
    en = 1'b1;
    cycle();
    check_output("stall_release_valid", longint'(m_ovalid), 0);

    // Streaming A, B then a 4-cycle stall with C held at the input.
    apply_stimulus(1, 1, 1, 1, 1, 1'b1);
    cycle();
    apply_stimulus(10, 0, 0, 0, 0, 1'b1);
    cycle();
    en = 1'b0;
    apply_stimulus(-1, -1, -1, -1, -1, 1'b1);
    repeat (4) cycle();
    en = 1'b1;
    for (int i = 0; i < 8; i++) begin
      cycle();
      if (i == 0) m_valid = 1'b0;
      if (m_ovalid) got.push_back(longint'(m_sum));
    end
    check_output("stream_count", longint'(got.size()), 3);
    check_output("stream_a", got.size() > 0 ? got[0] : -999999, 5);
    check_output("stream_b", got.size() > 1 ? got[1] : -999999, 10);
    check_output("stream_c", got.size() > 2 ? got[2] : -999999, -5);

    // Valid presented while stalled must be dropped.
    en = 1'b0;
    apply_stimulus(7, 7, 7, 7, 7, 1'b1);
    cycle();
    en = 1'b1;
    m_valid = 1'b0;
    for (int i = 0; i < 5; i++) begin
      cycle();
      check_output("ignored_valid", longint'(m_ovalid), 0);
    end

    // Reset between edges with a result at the output and two more in flight.
    apply_stimulus(1, 1, 1, 1, 1, 1'b1);
    cycle();
    apply_stimulus(2, 2, 2, 2, 2, 1'b1);
    cycle();
    apply_stimulus(3, 3, 3, 3, 3, 1'b1);
    cycle();
    m_valid = 1'b0;
    check_output("pre_reset_sum", longint'(m_sum), 5);
    #2 rst_n = 1'b0;
    #1;
    check_output("async_reset_valid", longint'(m_ovalid), 0);
    check_output("async_reset_sum", longint'(m_sum), 0);
    cycle();
    cycle();
    rst_n = 1'b1;
    for (int i = 0; i < 5; i++) begin
      cycle();
      check_output("post_reset_no_stale", longint'(m_ovalid), 0);
    end
    apply_stimulus(2, 2, 2, 2, 2, 1'b1);
    cycle();
    m_valid = 1'b0;
    cycle();
    cycle();
    check_output("post_reset_valid", longint'(m_ovalid), 1);
    check_output("post_reset_sum", longint'(m_sum), 10);

    // Odd and edge tree sizes, all launched together.
    d1 = 16'(-9);
    d3 = {16'(7), 16'(-50), 16'(100)};
    d8 = {8{16'h7FFF}};
    v1 = 1'b1;
    v3 = 1'b1;
    v8 = 1'b1;
    cycle();
    v1 = 1'b0;
    v3 = 1'b0;
    v8 = 1'b0;
    check_output("n1_valid", longint'(ov1), 1);
    check_output("n1_sum", longint'(s1), -9);
    check_output("n1_sat", longint'(sat1), 0);
    check_output("n3_early", longint'(ov3), 0);
    cycle();
    check_output("n1_valid_drop", longint'(ov1), 0);
    check_output("n3_valid", longint'(ov3), 1);
    check_output("n3_sum", longint'(s3), 57);
    check_output("n3_sat", longint'(sat3), 0);
    check_output("n8_early", longint'(ov8), 0);
    cycle();
    check_output("n8_valid", longint'(ov8), 1);
    check_output("n8_sum", longint'(s8), N8_EXP);
    check_output("n8_sat", longint'(sat8), N8_SAT);

    repeat (2) cycle();
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
